// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the 640x480@60 VGA sync generator.
// Holds the default porch/sync widths, derived totals and sync windows,
// the fixed counter width, and a small window-decode helper.
package vga_timing_pkg;

    localparam int CNT_W   = 10;
    localparam int CNT_MAX = 1 << CNT_W;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

    // True when lo <= value < hi; used for display-area and sync windows.
    function automatic logic inWindow(input logic [CNT_W-1:0] value, input int lo, input int hi);
        int v;
        v = int'(value);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/pixel_ce_divider.sv
// Pixel clock-enable generator: divides board_clk by CLK_DIV and emits a
// registered one-cycle pulse on the last count of each period.
// With CLK_DIV=1 the pulse is held high continuously once out of reset.
module pixel_ce_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic board_clk,
    input  logic reset,
    output logic pixel_ce
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             ce_q, ce_d;

    if (CLK_DIV < 1) begin : gBadDiv
        $error("pixel_ce_divider: CLK_DIV must be >= 1");
    end

    // Next divider count and the enable that goes with it, so pixel_ce is high exactly while the count sits on its last value.
    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        ce_d  = (div_d == DIV_LAST);
    end

    // Divider state and registered enable; both clear on reset.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            ce_q  <= ce_d;
        end
    end

    assign pixel_ce = ce_q;

endmodule

// File: rtl/vga_hvsync_generator.sv
// 640x480@60 VGA timing generator with pixel/line counters, sync pulses and
// a display-area flag. All flags are decoded from the next counter values and
// registered together with the counters, so they line up with CounterX/Y.
// Optional feature: define HVSYNC_FRAME_STROBE_EN to add the frame_start
// output, a one-cycle pulse when the counters wrap back to (0,0).
module vga_hvsync_generator
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic             board_clk,
    input  logic             reset,
    output logic             pixel_ce,
    output logic             vga_h_sync,
    output logic             vga_v_sync,
    output logic             inDisplayArea,
    output logic [CNT_W-1:0] CounterX,
    output logic [CNT_W-1:0] CounterY
`ifdef HVSYNC_FRAME_STROBE_EN
    ,
    output logic             frame_start
`endif
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : gBadTotals
        $error("vga_hvsync_generator: line/frame totals exceed 10-bit counters");
    end

    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             disp_q, disp_d;
    logic             lineWrap;
    logic             frameWrap;

    pixel_ce_divider #(
        .CLK_DIV (CLK_DIV)
    ) uDivider (
        .board_clk (board_clk),
        .reset     (reset),
        .pixel_ce  (pixel_ce)
    );

    // Next counter position and the flags decoded from it, so the registered flags match the registered counters.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        lineWrap  = (x_q == H_LAST);
        frameWrap = lineWrap && (y_q == V_LAST);
        if (pixel_ce) begin
            if (lineWrap) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
            end else begin
                x_d = x_q + CNT_W'(1);
            end
        end
        hs_d   = inWindow(x_d, H_SYNC_START, H_SYNC_END) ? HS_POL : ~HS_POL;
        vs_d   = inWindow(y_d, V_SYNC_START, V_SYNC_END) ? VS_POL : ~VS_POL;
        disp_d = inWindow(x_d, 0, H_ACTIVE) && inWindow(y_d, 0, V_ACTIVE);
    end

    // Counter and flag registers; reset lands on the top-left pixel with syncs inactive.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            disp_q <= 1'b1;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            disp_q <= disp_d;
        end
    end

    assign CounterX      = x_q;
    assign CounterY      = y_q;
    assign vga_h_sync    = hs_q;
    assign vga_v_sync    = vs_q;
    assign inDisplayArea = disp_q;

`ifdef HVSYNC_FRAME_STROBE_EN
    logic fs_q, fs_d;

    // Strobe for the cycle in which the counters have just wrapped to (0,0); reset itself never raises it.
    always_comb begin
        fs_d = pixel_ce && frameWrap;
    end

    // Frame strobe register.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            fs_q <= 1'b0;
        end else begin
            fs_q <= fs_d;
        end
    end

    assign frame_start = fs_q;
`endif

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Directed bench for vga_hvsync_generator. Horizontal timing is the default
// 640/16/96/48 line; the vertical timing is shrunk to 4/2/2/2 (10 lines per
// frame) so a whole frame, including the vertical sync and the Y wrap, fits in
// a short run. Expected values come from the edge count since reset release:
// pixel = edges/4, X = pixel mod 800, Y = (pixel div 800) mod 10.
// With HVSYNC_FRAME_STROBE_EN defined, frame_start is also checked.
module tb_vga_hvsync_generator;

    localparam int DIV     = 4;
    localparam int HTOT    = 800;
    localparam int VTOT    = 10;
    localparam int FRAME   = DIV * HTOT * VTOT;

    logic       board_clk = 1'b0;
    logic       reset     = 1'b1;
    logic       pixel_ce;
    logic       vga_h_sync;
    logic       vga_v_sync;
    logic       inDisplayArea;
    logic [9:0] CounterX;
    logic [9:0] CounterY;
`ifdef HVSYNC_FRAME_STROBE_EN
    logic       frame_start;
`endif

    int testCount   = 0;
    int failCount   = 0;
    int edgeCount   = 0;
    int hsLowCount  = 0;
    int vsLowCount  = 0;
    int ceCount     = 0;

    vga_hvsync_generator #(
        .CLK_DIV  (DIV),
        .V_ACTIVE (4),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (2)
    ) dut (
        .board_clk     (board_clk),
        .reset         (reset),
        .pixel_ce      (pixel_ce),
        .vga_h_sync    (vga_h_sync),
        .vga_v_sync    (vga_v_sync),
        .inDisplayArea (inDisplayArea),
        .CounterX      (CounterX),
        .CounterY      (CounterY)
`ifdef HVSYNC_FRAME_STROBE_EN
        ,
        .frame_start   (frame_start)
`endif
    );

    always #5 board_clk = ~board_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance to the given edge count, sampling each cycle on the falling edge.
    task automatic applyStimulus(input int target);
        while (edgeCount < target) begin
            @(posedge board_clk);
            edgeCount++;
            @(negedge board_clk);
            if (vga_h_sync === 1'b0) hsLowCount++;
            if (vga_v_sync === 1'b0) vsLowCount++;
            if (pixel_ce === 1'b1) ceCount++;
        end
    endtask

    // Compare every output against the position implied by edgeCount.
    task automatic checkPoint(input string tag);
        int pix, x, y;
        logic expHs, expVs, expDisp, expCe;
        pix     = edgeCount / DIV;
        x       = pix % HTOT;
        y       = (pix / HTOT) % VTOT;
        expCe   = ((edgeCount % DIV) == DIV - 1);
        expHs   = !((x >= 656) && (x < 752));
        expVs   = !((y >= 6) && (y < 8));
        expDisp = (x < 640) && (y < 4);
        checkOutput({tag, ".X"},    32'(CounterX),      32'(x));
        checkOutput({tag, ".Y"},    32'(CounterY),      32'(y));
        checkOutput({tag, ".hs"},   32'(vga_h_sync),    32'(expHs));
        checkOutput({tag, ".vs"},   32'(vga_v_sync),    32'(expVs));
        checkOutput({tag, ".disp"}, 32'(inDisplayArea), 32'(expDisp));
        checkOutput({tag, ".ce"},   32'(pixel_ce),      32'(expCe));
`ifdef HVSYNC_FRAME_STROBE_EN
        checkOutput({tag, ".fs"},   32'(frame_start),
                    32'((edgeCount > 0) && ((edgeCount % FRAME) == 0)));
`endif
    endtask

    initial begin
        // Reset held: top-left, syncs inactive, no enable.
        repeat (3) @(negedge board_clk);
        edgeCount = 0;
        checkPoint("reset");
        reset = 1'b0;

        // First enable after three edges, first X step on the fourth.
        applyStimulus(3);     checkPoint("e3");
        applyStimulus(4);     checkPoint("e4");
        applyStimulus(7);     checkPoint("e7");
        applyStimulus(8);     checkPoint("e8");

        // Horizontal boundaries of the first line.
        applyStimulus(2559);  checkPoint("x639");
        applyStimulus(2560);  checkPoint("x640");
        applyStimulus(2623);  checkPoint("x655");
        applyStimulus(2624);  checkPoint("x656");
        applyStimulus(3007);  checkPoint("x751");
        applyStimulus(3008);  checkPoint("x752");
        applyStimulus(3199);  checkPoint("x799");
        applyStimulus(3200);  checkPoint("y1x0");
        checkOutput("hsLowCycles", 32'(hsLowCount), 32'd384);
        checkOutput("cePulses",    32'(ceCount),    32'd800);

        // Vertical boundaries and the frame wrap.
        vsLowCount = 0;
        applyStimulus(12799); checkPoint("y3x799");
        applyStimulus(12800); checkPoint("y4x0");
        applyStimulus(19199); checkPoint("y5x799");
        applyStimulus(19200); checkPoint("y6x0");
        applyStimulus(25599); checkPoint("y7x799");
        applyStimulus(25600); checkPoint("y8x0");
        applyStimulus(31999); checkPoint("y9x799");
        applyStimulus(32000); checkPoint("wrap");
        applyStimulus(32001); checkPoint("wrap1");
        checkOutput("vsLowCycles",    32'(vsLowCount), 32'd6400);
        checkOutput("hsLowFrame",     32'(hsLowCount), 32'd3840);
        checkOutput("ceFramePulses",  32'(ceCount),    32'd8000);

        // Mid-frame reset at X=300, Y=2 returns to (0,0) at once.
        applyStimulus(39600); checkPoint("x300y2");
        reset = 1'b1;
        #1;
        edgeCount = 0;
        checkPoint("midReset");
        @(negedge board_clk);
        checkPoint("midResetHeld");
        reset = 1'b0;

        // Timing restarts from scratch after release.
        applyStimulus(3);     checkPoint("re3");
        applyStimulus(4);     checkPoint("re4");
        applyStimulus(3200);  checkPoint("rey1");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
